// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: CPU writes bytes into a small FIFO
// (DATA register); a serializer sends 8N1 frames on o_tx. STATUS reports FIFO/serializer/overflow.
module uart_tx_ctrl #(
  parameter logic [15:0] BASE_ADDR    = 16'h0F00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_dout,
  output logic        o_sel,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH     = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    dout_q, dout_d;
  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic sel_data, sel_stat, full, empty, pop, wr_data, push, ovf_hit;
  logic [7:0] status;

  assign sel_data = (i_addr == BASE_ADDR);
  assign sel_stat = (i_addr == STAT_ADDR);
  assign o_sel    = sel_data | sel_stat;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Pop decision uses the registered count, so a byte pushed into an empty FIFO waits one edge.
  assign pop     = (state_q == S_IDLE) && !empty;
  assign wr_data = !i_rw && sel_data;
  assign push    = wr_data && (!full || pop);
  assign ovf_hit = wr_data && full && !pop;

  assign status = {ovf_q, 4'b0000, (state_q != S_IDLE), empty, full};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    dout_d   = dout_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (ovf_hit)
      ovf_d = 1'b1;
    else if (!i_rw && sel_stat && i_din[7])
      ovf_d = 1'b0;
    if (i_rw && sel_stat)
      dout_d = status;
    else if (i_rw && sel_data)
      dout_d = 8'h00;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == CNT_LAST) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == CNT_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == CNT_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem_q[wr_ptr_q] <= i_din;
  end

  assign o_dout = dout_q;
  assign o_tx   = tx_q;
  assign o_busy = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (CLKS_PER_BIT=4, FIFO_DEPTH=4): a negedge monitor
// decodes frames and checks them against a queue of expected bytes.
module tb_uart_tx_ctrl;
  localparam int CPB = 4;
  localparam logic [15:0] DATA_A = 16'h0F00;
  localparam logic [15:0] STAT_A = 16'h0F01;

  logic        clk, rst, rw, sel, tx, busy;
  logic [15:0] addr;
  logic [7:0]  din, dout;

  int tests = 0;
  int fails = 0;
  int frames = 0;
  logic [7:0] sb_q[$];
  int gaps_q[$];

  uart_tx_ctrl #(.BASE_ADDR(16'h0F00), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_rw(rw), .i_din(din),
    .o_dout(dout), .o_sel(sel), .o_tx(tx), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at a negedge, let one rising edge pass, return at the following negedge.
  task automatic bus(input logic r, input logic [15:0] a, input logic [7:0] d);
    rw = r; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus(1'b1, 16'h0000, 8'h00);
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus(1'b1, a, 8'h00);
    check(tag, {8'h00, dout}, {8'h00, exp});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      idle();
      n++;
    end
    check(tag, {15'd0, busy}, 16'd0);
    repeat (3) idle();
  endtask

  // Frame monitor
  initial begin
    int hr = 0;
    logic samp [10*CPB];
    logic aborted, ok;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin hr = 0; continue; end
      if (tx === 1'b1) begin hr++; continue; end
      gaps_q.push_back(hr);
      aborted = 1'b0;
      samp[0] = tx;
      for (int i = 1; i < 10*CPB; i++) begin
        @(negedge clk);
        if (rst !== 1'b0) aborted = 1'b1;
        samp[i] = tx;
      end
      hr = 0;
      if (aborted) continue;
      ok = (samp[0] === 1'b0) && (samp[9*CPB] === 1'b1);
      for (int w = 0; w < 10; w++)
        for (int j = 1; j < CPB; j++)
          if (samp[w*CPB+j] !== samp[w*CPB]) ok = 1'b0;
      for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*CPB];
      frames++;
      check("frame_format", {15'd0, ok}, 16'd1);
      if (sb_q.size() == 0)
        check("frame_unexpected", {8'h00, b}, 16'hFFFF);
      else
        check("frame_data", {8'h00, b}, {8'h00, sb_q.pop_front()});
    end
  end

  initial begin
    logic [7:0] pat;
    logic exp_bit;
    int f0, lows;
    rst = 1'b1; rw = 1'b1; addr = 16'h0000; din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {15'd0, tx}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_dout", {8'h00, dout}, 16'h0000);
    check("rst_sel", {15'd0, sel}, 16'd0);
    rst = 1'b0;
    read_chk("status_after_rst", STAT_A, 8'h02);

    // Single frame, exact waveform
    pat = 8'h55;
    sb_q.push_back(pat);
    bus(1'b0, DATA_A, pat);
    check("latency_tx_still_high", {15'd0, tx}, 16'd1);
    for (int k = 1; k <= 40; k++) begin
      idle();
      if ((k-1)/CPB == 0) exp_bit = 1'b0;
      else if ((k-1)/CPB == 9) exp_bit = 1'b1;
      else exp_bit = pat[(k-1)/CPB - 1];
      check($sformatf("wave_0x55_cyc%0d", k), {15'd0, tx}, {15'd0, exp_bit});
    end
    check("busy_before_end", {15'd0, busy}, 16'd1);
    idle();
    check("busy_falls_N41", {15'd0, busy}, 16'd0);
    wait_idle("idle_after_55");

    // Back-to-back frames
    sb_q.push_back(8'hA1); sb_q.push_back(8'h3C);
    bus(1'b0, DATA_A, 8'hA1);
    bus(1'b0, DATA_A, 8'h3C);
    wait_idle("idle_after_a1_3c");
    check("interframe_gap", 16'(gaps_q[gaps_q.size()-1]), 16'd1);

    // Overflow: 6 writes, 5 kept
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb_q.push_back(8'h10 + 8'(i));
      bus(1'b0, DATA_A, 8'h10 + 8'(i));
    end
    read_chk("status_overflow", STAT_A, 8'h85);
    bus(1'b0, STAT_A, 8'h80);
    read_chk("status_ovf_cleared", STAT_A, 8'h05);
    wait_idle("idle_after_overflow");
    read_chk("status_drained", STAT_A, 8'h02);

    // Push on the exact edge of a pop while full
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(8'h20 + 8'(i));
      bus(1'b0, DATA_A, 8'h20 + 8'(i));
    end
    read_chk("status_full", STAT_A, 8'h05);
    repeat (36) idle();
    sb_q.push_back(8'h25);
    bus(1'b0, DATA_A, 8'h25);
    read_chk("status_push_on_pop", STAT_A, 8'h05);
    wait_idle("idle_after_push_on_pop");
    check("sb_empty_mid", 16'(sb_q.size()), 16'd0);

    // Reset mid-frame, with a write during reset
    bus(1'b0, DATA_A, 8'h5A);
    repeat (9) idle();
    f0 = frames;
    rst = 1'b1;
    bus(1'b0, DATA_A, 8'h77);
    check("rst_mid_tx", {15'd0, tx}, 16'd1);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    read_chk("status_after_mid_rst", STAT_A, 8'h02);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      idle();
      if (tx !== 1'b1) lows++;
    end
    check("no_activity_after_rst", 16'(lows), 16'd0);
    check("no_frame_after_rst", 16'(frames - f0), 16'd0);

    // Address decode and foreign accesses
    read_chk("read_data_reg", DATA_A, 8'h00);
    read_chk("status_again", STAT_A, 8'h02);
    addr = 16'h1234; #1;
    check("sel_1234", {15'd0, sel}, 16'd0);
    addr = DATA_A; #1;
    check("sel_data", {15'd0, sel}, 16'd1);
    addr = STAT_A; #1;
    check("sel_stat", {15'd0, sel}, 16'd1);
    addr = 16'h0F02; #1;
    check("sel_0f02", {15'd0, sel}, 16'd0);
    bus(1'b0, 16'h1234, 8'h99);
    check("dout_hold_foreign_wr", {8'h00, dout}, 16'h0002);
    bus(1'b1, 16'h1234, 8'h00);
    check("dout_hold_foreign_rd", {8'h00, dout}, 16'h0002);
    repeat (3) idle();
    check("busy_after_foreign", {15'd0, busy}, 16'd0);
    read_chk("status_after_foreign", STAT_A, 8'h02);
    repeat (10) idle();
    check("sb_empty_end", 16'(sb_q.size()), 16'd0);
    check("frame_total", 16'(frames), 16'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0F00, address of the DATA register; STATUS is at BASE_ADDR+1.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..256).
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_addr  input  16  CPU bus address.
REQ-007 i_rw  input  1  CPU read/write strobe; 1 = read, 0 = write.
REQ-008 i_din  input  8  CPU write data.
REQ-009 o_dout  output  8  registered read data.
REQ-010 o_sel  output  1  combinational; 1 when i_addr is BASE_ADDR or BASE_ADDR+1.
REQ-011 o_tx  output  1  serial line, idle high.
REQ-012 o_busy  output  1  1 when FIFO non-empty or serializer not IDLE.

Function
REQ-013 Write to DATA (i_rw=0, i_addr=BASE_ADDR) SHALL push i_din into the FIFO at that edge when FIFO not full.
REQ-014 Write to DATA while full SHALL drop the byte and set sticky overflow, unless a pop occurs on the same edge, in which case the push SHALL be accepted and the count SHALL be unchanged.
REQ-015 Write to STATUS with i_din[7]=1 SHALL clear overflow; other bits of the write SHALL be ignored; a simultaneous overflow-set SHALL win.
REQ-016 STATUS layout: bit0 fifo_full, bit1 fifo_empty, bit2 serializer active (state != IDLE), bit7 overflow, bits 6:3 zero.
REQ-017 Read (i_rw=1) of STATUS SHALL load o_dout with STATUS at the edge; read of DATA SHALL load 8'h00; o_dout SHALL hold its value on all other cycles.
REQ-018 Accesses to any other address SHALL have no effect.
REQ-019 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE with FIFO non-empty SHALL pop the head byte into the shift register and go to START on that edge; pushes into an empty FIFO SHALL not be popped on the same edge.
REQ-021 START: o_tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-022 DATA: 8 bits LSB first, each for exactly CLKS_PER_BIT cycles, tracked by a 3-bit bit counter, then STOP.
REQ-023 STOP: o_tx=1 for exactly CLKS_PER_BIT cycles, then IDLE.
REQ-024 o_tx SHALL be registered; frame = 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-025 Latency: DATA write at edge N into an empty idle block -> pop at edge N+1 -> o_tx low from edge N+1.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 On i_rst: FIFO empty, overflow=0, state IDLE, counters 0, o_tx=1, o_dout=8'h00, o_busy=0.
REQ-028 Reset mid-frame SHALL abort the frame, discard FIFO contents, and drive o_tx=1 from the next edge.
REQ-029 Bus writes during reset SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Write 8'h55 to 0x0F00 at edge N -> o_tx = 0 for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; o_busy falls at edge N+41.
REQ-031 Write 8'hA1 then 8'h3C on consecutive edges -> two frames, LSB first, with exactly one idle-high cycle between stop and start.
REQ-032 Write 6 bytes back-to-back while the first frame is in flight -> 5 bytes transmitted, 6th dropped, STATUS read = 8'h85 (full, active, overflow); then write 8'h80 to 0x0F01 -> overflow clears.
REQ-033 Fill the FIFO; write on the exact edge the serializer pops -> byte accepted, overflow stays 0, all bytes transmitted in order.
REQ-034 Assert i_rst for 1 cycle at cycle 10 of a frame -> o_tx=1 the next cycle, STATUS read = 8'h02, no further serial activity.
REQ-035 Read 0x0F00 and write 0x1234 -> o_dout=8'h00, o_sel=0 for 0x1234, no FIFO change.
